// File: rtl/vga_mapa_render.sv
`timescale 1ns/1ps
// 640x480@60 raster generator that draws one player's 8x8 naval board from
// frame-latched shadow copies of the fleet occupancy vectors.
module vga_mapa_render #(
    parameter int unsigned CELULA = 32,
    parameter int unsigned X0     = 192,
    parameter int unsigned Y0     = 112
) (
    input  logic         clk,
    input  logic         resetGeral,
    input  logic         exibeMapa,
    input  logic         jogadorVGA,
    input  logic [703:0] embarcacoes,
    output logic         hsync,
    output logic         vsync,
    output logic [11:0]  rgb,
    output logic         visivel,
    output logic         fim_quadro
);

    localparam int unsigned CW    = 10;
    localparam int unsigned BW    = 11;
    localparam int unsigned NSLOT = 11;
    localparam int unsigned LOG2C = $clog2(CELULA);

    localparam logic [CW-1:0] H_LAST   = CW'(799);
    localparam logic [CW-1:0] V_LAST   = CW'(524);
    localparam logic [CW-1:0] H_ACT    = CW'(640);
    localparam logic [CW-1:0] V_ACT    = CW'(480);
    localparam logic [CW-1:0] HS_BEG   = CW'(656);
    localparam logic [CW-1:0] HS_END   = CW'(751);
    localparam logic [CW-1:0] VS_BEG   = CW'(490);
    localparam logic [CW-1:0] VS_END   = CW'(491);
    localparam logic [CW-1:0] BAR_ROWS = CW'(16);

    localparam logic [BW-1:0] BX0  = BW'(X0);
    localparam logic [BW-1:0] BX1  = BW'(X0 + 8 * CELULA);
    localparam logic [BW-1:0] BY0  = BW'(Y0);
    localparam logic [BW-1:0] BY1  = BW'(Y0 + 8 * CELULA);
    localparam logic [BW-1:0] MASK = BW'(CELULA - 1);

    localparam logic [11:0] C_BLACK = 12'h000;
    localparam logic [11:0] C_GRID  = 12'hFFF;
    localparam logic [11:0] C_WATER = 12'h00F;
    localparam logic [11:0] C_SUB   = 12'hFF0;
    localparam logic [11:0] C_CRU   = 12'hF80;
    localparam logic [11:0] C_SEA   = 12'h0F0;
    localparam logic [11:0] C_BAT   = 12'hF00;
    localparam logic [11:0] C_CAR   = 12'hF0F;
    localparam logic [11:0] C_J0    = 12'h0FF;
    localparam logic [11:0] C_J1    = 12'hF0F;

    // Cell coordinates come from shifts and masks, so the cell size must be 2^n.
    if ((CELULA == 0) || ((CELULA & (CELULA - 1)) != 0)) begin : g_celula_check
        $error("CELULA must be a power of two");
    end

    logic [CW-1:0]  h;
    logic [CW-1:0]  v;
    logic [703:0]   sh_emb;
    logic           sh_exibe;
    logic           sh_jog;
    logic           fim_c;

    assign fim_c = (h == H_LAST) && (v == V_LAST);

    // Raster counters
    always_ff @(posedge clk) begin
        if (resetGeral) begin
            h <= '0;
            v <= '0;
        end else if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : CW'(v + CW'(1));
        end else begin
            h <= CW'(h + CW'(1));
        end
    end

    // Frame-boundary shadow copies keep each frame internally consistent
    always_ff @(posedge clk) begin
        if (resetGeral) begin
            sh_emb   <= '0;
            sh_exibe <= 1'b0;
            sh_jog   <= 1'b0;
        end else if (fim_c) begin
            sh_emb   <= embarcacoes;
            sh_exibe <= exibeMapa;
            sh_jog   <= jogadorVGA;
        end
    end

    logic [BW-1:0] hx;
    logic [BW-1:0] vx;
    logic [BW-1:0] dx;
    logic [BW-1:0] dy;
    logic          in_board;
    logic          on_grid;
    logic [2:0]    col;
    logic [2:0]    lin;
    logic [5:0]    idx;
    logic [NSLOT-1:0] occ;

    always_comb begin
        hx       = {1'b0, h};
        vx       = {1'b0, v};
        dx       = BW'(hx - BX0);
        dy       = BW'(vx - BY0);
        in_board = (hx >= BX0) && (hx < BX1) && (vx >= BY0) && (vx < BY1);
        on_grid  = ((dx & MASK) == '0) || ((dy & MASK) == '0);
        col      = 3'(dx >> LOG2C);
        lin      = 3'(dy >> LOG2C);
        idx      = {lin, col};
    end

    for (genvar k = 0; k < NSLOT; k++) begin : g_occ
        logic [63:0] slot_word;
        assign slot_word = sh_emb[64*k +: 64];
        assign occ[k]    = slot_word[idx];
    end

    logic       active;
    logic [11:0] pix;

    // Slot classes are contiguous in ascending index, so class order is index priority
    always_comb begin
        active = (h < H_ACT) && (v < V_ACT);
        pix    = C_BLACK;
        if (active && sh_exibe) begin
            if (v < BAR_ROWS) begin
                pix = sh_jog ? C_J1 : C_J0;
            end else if (in_board) begin
                if (on_grid)            pix = C_GRID;
                else if (|occ[4:0])     pix = C_SUB;
                else if (|occ[6:5])     pix = C_CRU;
                else if (|occ[8:7])     pix = C_SEA;
                else if (occ[9])        pix = C_BAT;
                else if (occ[10])       pix = C_CAR;
                else                    pix = C_WATER;
            end
        end
    end

    // All outputs describe the counter state of the previous cycle
    always_ff @(posedge clk) begin
        if (resetGeral) begin
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            rgb        <= C_BLACK;
            visivel    <= 1'b0;
            fim_quadro <= 1'b0;
        end else begin
            hsync      <= !((h >= HS_BEG) && (h <= HS_END));
            vsync      <= !((v >= VS_BEG) && (v <= VS_END));
            rgb        <= pix;
            visivel    <= active;
            fim_quadro <= fim_c;
        end
    end

endmodule

// File: tb/tb_vga_mapa_render.sv
`timescale 1ns/1ps
// Scoreboard bench for vga_mapa_render: directed pixel probes queued per frame,
// timing outputs checked every cycle against a raster position model.
module tb_vga_mapa_render;

    logic         clk = 1'b0;
    logic         reset_geral;
    logic         exibe;
    logic         jog;
    logic [703:0] emb;
    logic         hsync;
    logic         vsync;
    logic [11:0]  rgb;
    logic         visivel;
    logic         fim_quadro;

    always #20 clk = ~clk;

    vga_mapa_render dut (
        .clk        (clk),
        .resetGeral (reset_geral),
        .exibeMapa  (exibe),
        .jogadorVGA (jog),
        .embarcacoes(emb),
        .hsync      (hsync),
        .vsync      (vsync),
        .rgb        (rgb),
        .visivel    (visivel),
        .fim_quadro (fim_quadro)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Raster position model: c* = counter state, o* = state the outputs describe
    int ch = 0, cv = 0, oh = 0, ov = 0;
    bit o_valid = 1'b0;
    bit o_rst   = 1'b0;

    always @(posedge clk) begin
        if (reset_geral) begin
            ch <= 0; cv <= 0; o_valid <= 1'b0; o_rst <= 1'b1;
        end else begin
            oh <= ch; ov <= cv; o_valid <= 1'b1; o_rst <= 1'b0;
            if (ch == 799) begin
                ch <= 0;
                cv <= (cv == 524) ? 0 : cv + 1;
            end else begin
                ch <= ch + 1;
            end
        end
    end

    typedef struct {
        int h;
        int v;
        int rgb;
    } probe_t;

    probe_t q[$];

    task automatic push(input int h, input int v, input int c);
        probe_t p;
        p.h = h; p.v = v; p.rgb = c;
        q.push_back(p);
    endtask

    // Monitor
    int  cyc = 0;
    int  last_hfall = -1, last_vfall = -1, last_fim = -1;
    int  fim_count = 0;
    bit  prev_h = 1'b1, prev_v = 1'b1;

    always @(negedge clk) begin
        bit exp_vis, exp_h, exp_v, exp_f;
        probe_t p;
        cyc++;
        if (o_rst) begin
            check("reset_hsync", int'(hsync), 1);
            check("reset_vsync", int'(vsync), 1);
            check("reset_visivel", int'(visivel), 0);
            check("reset_fim", int'(fim_quadro), 0);
            check("reset_rgb", int'(rgb), 0);
            last_hfall = -1; last_vfall = -1; last_fim = -1;
            prev_h = 1'b1; prev_v = 1'b1;
        end else if (o_valid) begin
            exp_vis = (oh < 640) && (ov < 480);
            exp_h   = !((oh >= 656) && (oh <= 751));
            exp_v   = !((ov >= 490) && (ov <= 491));
            exp_f   = (oh == 799) && (ov == 524);
            check("visivel", int'(visivel), int'(exp_vis));
            check("hsync", int'(hsync), int'(exp_h));
            check("vsync", int'(vsync), int'(exp_v));
            check("fim_quadro", int'(fim_quadro), int'(exp_f));
            if (!exp_vis) check("rgb_blank", int'(rgb), 0);
            if (prev_h && !hsync) begin
                if (last_hfall >= 0) check("hsync_period", cyc - last_hfall, 800);
                last_hfall = cyc;
            end
            if (!prev_h && hsync && last_hfall >= 0) check("hsync_low", cyc - last_hfall, 96);
            if (prev_v && !vsync) begin
                if (last_vfall >= 0) check("vsync_period", cyc - last_vfall, 420000);
                last_vfall = cyc;
            end
            if (!prev_v && vsync && last_vfall >= 0) check("vsync_low", cyc - last_vfall, 1600);
            if (fim_quadro) begin
                fim_count++;
                if (last_fim >= 0) check("fim_period", cyc - last_fim, 420000);
                last_fim = cyc;
            end
            if (q.size() > 0 && q[0].h == oh && q[0].v == ov) begin
                p = q.pop_front();
                check($sformatf("rgb(%0d,%0d)", p.h, p.v), int'(rgb), p.rgb);
            end
            prev_h = hsync;
            prev_v = vsync;
        end
    end

    task automatic wait_coord(input int h, input int v);
        do @(negedge clk); while (!(ch == h && cv == v));
    endtask

    initial begin
        reset_geral = 1'b1;
        exibe       = 1'b0;
        jog         = 1'b0;
        emb         = '0;
        repeat (3) @(negedge clk);
        emb[0*64 + 0]  = 1'b1;
        emb[3*64 + 63] = 1'b1;
        emb[10*64 + 63] = 1'b1;
        emb[10*64 + 9] = 1'b1;
        emb[5*64 + 2]  = 1'b1;
        emb[7*64 + 3]  = 1'b1;
        emb[9*64 + 4]  = 1'b1;
        exibe = 1'b1;
        jog   = 1'b1;
        reset_geral = 1'b0;

        // Frame 1: shadows still clear, so everything is black
        push(100, 5, 12'h000);
        push(200, 120, 12'h000);
        push(440, 360, 12'h000);

        // Frame 2: map shown for player 1
        wait_coord(0, 0);
        push(100, 5, 12'hF0F);
        push(650, 5, 12'h000);
        push(100, 20, 12'h000);
        push(200, 112, 12'hFFF);
        push(192, 120, 12'hFFF);
        push(200, 120, 12'hFF0);
        push(240, 120, 12'h00F);
        push(280, 120, 12'hF80);
        push(300, 120, 12'h0F0);
        push(330, 120, 12'hF00);
        push(240, 150, 12'hF0F);
        push(191, 200, 12'h000);
        push(448, 200, 12'h000);
        push(440, 360, 12'hFF0);
        push(447, 367, 12'hFF0);
        wait_coord(0, 200);
        exibe = 1'b0;
        jog   = 1'b0;

        // Frame 3: display disabled
        wait_coord(0, 0);
        push(100, 5, 12'h000);
        push(200, 120, 12'h000);
        push(440, 360, 12'h000);
        wait_coord(0, 400);
        exibe = 1'b1;

        // Frame 4: map shown for player 0, then reset mid-frame
        wait_coord(0, 0);
        push(100, 5, 12'h0FF);
        push(200, 120, 12'hFF0);
        wait_coord(300, 250);
        reset_geral = 1'b1;
        @(negedge clk);
        reset_geral = 1'b0;

        // Frame after reset: black again
        push(100, 5, 12'h000);
        push(200, 120, 12'h000);
        wait_coord(0, 200);

        check("probes_left", q.size(), 0);
        check("fim_count", fim_count, 3);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
